// File: rtl/rca_cfg_sequencer.sv
// RCA configuration sequencer: takes one config instruction at a time, locks the target RCA,
// drains in-flight use, issues a single config-store write and holds the lock through mux settling.
module rca_cfg_sequencer #(
    parameter int NUM_RCAS       = 4,
    parameter int NUM_GRID_MUXES = 72,
    parameter int NUM_IO_UNITS   = 14,
    parameter int SETTLE_CYCLES  = 4,
    parameter int CFG_DATA_W     = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic [2:0]                  issue_funct3,
    input  logic [6:0]                  issue_funct7,
    input  logic [31:0]                 issue_rs1,
    input  logic [31:0]                 issue_rs2,
    input  logic [NUM_RCAS-1:0]         rca_busy,
    output logic [NUM_RCAS-1:0]         rca_cfg_lock,
    output logic                        cfg_we,
    output logic [2:0]                  cfg_type,
    output logic [$clog2(NUM_RCAS)-1:0] cfg_rca,
    output logic [6:0]                  cfg_addr,
    output logic [CFG_DATA_W-1:0]       cfg_data,
    output logic                        cfg_done,
    output logic                        cfg_err
);

    localparam int RCA_W = $clog2(NUM_RCAS);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRAIN  = 3'd1;
    localparam logic [2:0] S_WRITE  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [2:0] F3_GRID_MUX = 3'b010;
    localparam logic [2:0] F3_IO_MUX   = 3'b011;

    logic [2:0]            state_q;
    logic [2:0]            type_q;
    logic [RCA_W-1:0]      rca_q;
    logic [6:0]            addr_q;
    logic [CFG_DATA_W-1:0] data_q;
    logic [CNT_W-1:0]      settle_q;
    logic                  err_q;

    logic accept;
    logic bad_cmd;
    logic needs_settle;
    logic unused_rs2_hi;

    // rs2 bits above the register index are deliberately dropped without raising an error.
    assign unused_rs2_hi = ^issue_rs2[31:CFG_DATA_W];

    assign accept = issue_valid && (state_q == S_IDLE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        bad_cmd = 1'b0;
        case (issue_funct3)
            3'b000, 3'b110, 3'b111: bad_cmd = 1'b1;
            F3_GRID_MUX: if (issue_rs1 >= 32'(NUM_GRID_MUXES)) bad_cmd = 1'b1;
            F3_IO_MUX:   if (issue_rs1 >= 32'(NUM_IO_UNITS))   bad_cmd = 1'b1;
            default: ;
        endcase
        if ({25'd0, issue_funct7} >= 32'(NUM_RCAS)) bad_cmd = 1'b1;
    end

    assign needs_settle = (SETTLE_CYCLES > 0) &&
                          ((type_q == F3_GRID_MUX) || (type_q == F3_IO_MUX));

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            type_q   <= '0;
            rca_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            settle_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (bad_cmd) begin
                            err_q <= 1'b1;
                        end else begin
                            type_q  <= issue_funct3;
                            rca_q   <= issue_funct7[RCA_W-1:0];
                            addr_q  <= issue_rs1[6:0];
                            data_q  <= issue_rs2[CFG_DATA_W-1:0];
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!rca_busy[rca_q]) state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (needs_settle) begin
                        settle_q <= CNT_W'(SETTLE_CYCLES);
                        state_q  <= S_SETTLE;
                    end else begin
                        state_q <= S_DONE;
                    end
                end
                S_SETTLE: begin
                    settle_q <= settle_q - 1'b1;
                    if (settle_q == CNT_W'(1)) state_q <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Lock is a pure decode of the busy states, so it drops on the edge entering DONE
    // and can only ever name the single latched target.
    always_comb begin
        rca_cfg_lock = '0;
        if ((state_q == S_DRAIN) || (state_q == S_WRITE) || (state_q == S_SETTLE))
            rca_cfg_lock[rca_q] = 1'b1;
    end

    assign issue_ready = (state_q == S_IDLE);
    assign cfg_we      = (state_q == S_WRITE);
    assign cfg_done    = (state_q == S_DONE);
    assign cfg_err     = err_q;
    assign cfg_type    = type_q;
    assign cfg_rca     = rca_q;
    assign cfg_addr    = addr_q;
    assign cfg_data    = data_q;

endmodule
